// File: rtl/trigger_input_detector_pkg.sv
// Shared types and constants for the trigger input detector: FSM states,
// crossing side, edge-select codes and the EXT source-select value.
package trigger_input_detector_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARMING     = 2'd1,
        WAIT_CROSS = 2'd2,
        HOLDOFF    = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_BELOW = 1'b0,
        SIDE_ABOVE = 1'b1
    } side_t;

    localparam logic [1:0] E_POS  = 2'b00;
    localparam logic [1:0] E_NEG  = 2'b01;
    localparam logic [1:0] E_BOTH = 2'b10;

    // Select value that picks the external trigger: it sits just past the channels.
    function automatic int sel_ext(input int n_ch);
        return n_ch;
    endfunction

endpackage

// File: rtl/trigger_source_mux.sv
// Registered trigger source stage: picks one ADC channel or the external
// trigger (replicated across the sample width), or nothing when disabled.
module trigger_source_mux
    import trigger_input_detector_pkg::*;
#(
    parameter int BITS_ADC  = 8,
    parameter int N_CH      = 2,
    parameter int SEL_WIDTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic [N_CH*BITS_ADC-1:0] ch_in,
    input  logic [N_CH-1:0]          ch_rdy,
    input  logic                     ext_in,
    input  logic [SEL_WIDTH-1:0]     sel,
    output logic [BITS_ADC-1:0]      sample_out,
    output logic                     sample_rdy_out
);

    localparam logic [SEL_WIDTH-1:0] SEL_EXT = SEL_WIDTH'(sel_ext(N_CH));

    logic [BITS_ADC-1:0] mux_sample;
    logic                mux_rdy;

    // EXT paces itself on any channel's ready so it lines up with the ADC stream.
    always_comb begin
        mux_sample = '0;
        mux_rdy    = 1'b0;
        if (sel == SEL_EXT) begin
            mux_sample = {BITS_ADC{ext_in}};
            mux_rdy    = |ch_rdy;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel == SEL_WIDTH'(k)) begin
                    mux_sample = ch_in[k*BITS_ADC +: BITS_ADC];
                    mux_rdy    = ch_rdy[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            sample_out     <= '0;
            sample_rdy_out <= 1'b0;
        end else begin
            sample_out     <= mux_sample;
            sample_rdy_out <= mux_rdy;
        end
    end

endmodule

// File: rtl/trigger_input_detector.sv
// Level-crossing trigger detector with hysteresis arming, edge select and a
// holdoff counted in ready samples; feeds the buffer controller.
module trigger_input_detector
    import trigger_input_detector_pkg::*;
#(
    parameter int BITS_ADC      = 8,
    parameter int N_CH          = 2,
    parameter int SEL_WIDTH     = 3,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic [N_CH*BITS_ADC-1:0] ch_in,
    input  logic [N_CH-1:0]          ch_rdy,
    input  logic                     ext_in,
    input  logic [BITS_ADC-1:0]      trigger_value_in,
    input  logic [BITS_ADC-1:0]      trigger_hyst_in,
    input  logic [SEL_WIDTH-1:0]     trigger_source_sel,
    input  logic [1:0]               trigger_edge_type,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_in,
    input  logic                     arm_in,
    output logic [BITS_ADC-1:0]      sample_out,
    output logic                     sample_rdy_out,
    output logic                     trigger_out,
    output logic                     armed_out,
    output state_t                   state_dbg
);

    localparam logic [SEL_WIDTH-1:0] SEL_EXT   = SEL_WIDTH'(sel_ext(N_CH));
    localparam logic [BITS_ADC-1:0]  EXT_VALUE = {1'b1, {(BITS_ADC-1){1'b0}}};

    state_t                   state, state_nxt;
    side_t                    side, side_nxt;
    logic [HOLDOFF_WIDTH-1:0] cnt, cnt_nxt;
    logic                     trig_nxt;
    logic                     load_cfg;

    logic [SEL_WIDTH-1:0]     cfg_sel;
    logic [1:0]               cfg_edge;
    logic [BITS_ADC-1:0]      cfg_value;
    logic [BITS_ADC-1:0]      cfg_hyst;
    logic [HOLDOFF_WIDTH-1:0] cfg_holdoff;

    logic [SEL_WIDTH-1:0]     src_sel;
    logic [BITS_ADC-1:0]      src_sample;
    logic                     src_rdy;

    logic [BITS_ADC-1:0]      lo, hi;
    logic [BITS_ADC:0]        hi_sum;
    logic                     pos_sel, neg_sel, crossed;

    // On the edge that enters ARMING the mux already follows the new source,
    // so the first sample seen in ARMING comes from the freshly latched channel.
    assign src_sel = load_cfg ? trigger_source_sel : cfg_sel;

    trigger_source_mux #(
        .BITS_ADC (BITS_ADC),
        .N_CH     (N_CH),
        .SEL_WIDTH(SEL_WIDTH)
    ) u_src (
        .clk_i         (clk_i),
        .rst           (rst),
        .ch_in         (ch_in),
        .ch_rdy        (ch_rdy),
        .ext_in        (ext_in),
        .sel           (src_sel),
        .sample_out    (src_sample),
        .sample_rdy_out(src_rdy)
    );

    assign sample_out     = src_sample;
    assign sample_rdy_out = src_rdy;
    assign state_dbg      = state;

    always_comb begin
        lo      = (cfg_value >= cfg_hyst) ? (cfg_value - cfg_hyst) : '0;
        hi_sum  = {1'b0, cfg_value} + {1'b0, cfg_hyst};
        hi      = hi_sum[BITS_ADC] ? '1 : hi_sum[BITS_ADC-1:0];
        pos_sel = (cfg_edge == E_POS) || (cfg_edge == E_BOTH) || (cfg_edge == 2'b11);
        neg_sel = (cfg_edge == E_NEG) || (cfg_edge == E_BOTH);
        crossed = (side == SIDE_BELOW) ? (src_sample >= cfg_value)
                                       : (src_sample <= cfg_value);
    end

    always_comb begin
        state_nxt = state;
        side_nxt  = side;
        cnt_nxt   = cnt;
        trig_nxt  = 1'b0;
        load_cfg  = 1'b0;
        case (state)
            IDLE: begin
                if (arm_in) begin
                    state_nxt = ARMING;
                    load_cfg  = 1'b1;
                end
            end
            ARMING: begin
                if (src_rdy) begin
                    if (pos_sel && (src_sample < lo)) begin
                        side_nxt  = SIDE_BELOW;
                        state_nxt = WAIT_CROSS;
                    end else if (neg_sel && (src_sample > hi)) begin
                        side_nxt  = SIDE_ABOVE;
                        state_nxt = WAIT_CROSS;
                    end
                end
            end
            WAIT_CROSS: begin
                if (src_rdy && crossed) begin
                    trig_nxt = 1'b1;
                    if (cfg_holdoff == '0) begin
                        state_nxt = ARMING;
                        load_cfg  = 1'b1;
                    end else begin
                        state_nxt = HOLDOFF;
                        cnt_nxt   = cfg_holdoff;
                    end
                end
            end
            HOLDOFF: begin
                // The H-th ready in holdoff releases it, so ready H+1 is the first re-arm look.
                if (src_rdy) begin
                    if (cnt <= HOLDOFF_WIDTH'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = ARMING;
                        load_cfg  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - HOLDOFF_WIDTH'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!arm_in) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            load_cfg  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state       <= IDLE;
            side        <= SIDE_BELOW;
            cnt         <= '0;
            trigger_out <= 1'b0;
            armed_out   <= 1'b0;
            cfg_sel     <= '0;
            cfg_edge    <= E_POS;
            cfg_value   <= '0;
            cfg_hyst    <= '0;
            cfg_holdoff <= '0;
        end else begin
            state       <= state_nxt;
            side        <= side_nxt;
            cnt         <= cnt_nxt;
            trigger_out <= trig_nxt;
            armed_out   <= (state_nxt == ARMING) || (state_nxt == WAIT_CROSS);
            if (load_cfg) begin
                cfg_sel     <= trigger_source_sel;
                cfg_edge    <= trigger_edge_type;
                cfg_holdoff <= holdoff_in;
                if (trigger_source_sel == SEL_EXT) begin
                    cfg_value <= EXT_VALUE;
                    cfg_hyst  <= '0;
                end else begin
                    cfg_value <= trigger_value_in;
                    cfg_hyst  <= trigger_hyst_in;
                end
            end
        end
    end

endmodule
